gp_reg_scoreboard: RTL

//  Issue-side scoreboard for the 32x32 general-purpose register file in the multi-cycle MIPS core.
//  - Tracks one pending-write (busy) bit per GPR, including the JAL return-address write to $31.
//  - Grants or blocks instruction issue on RAW/WAW hazards and on an outstanding-write limit.
//  - Sits between decode (issue) and the writeback paths that drive RegWrite and JAL_write.

---
 rtl/gp_reg_scoreboard_if.sv | 29 ++
 rtl/gp_reg_scoreboard.sv | 97 +++++++++
 2 files changed

// File: rtl/gp_reg_scoreboard_if.sv
// rtl/gp_reg_scoreboard_if.sv - issue and writeback bundle for the GPR scoreboard
interface gp_reg_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_use_rs;
  logic       issue_use_rt;
  logic       issue_wr;
  logic [4:0] issue_dst;
  logic       issue_jal;
  logic       issue_ready;
  logic       wb_valid;
  logic [4:0] wb_reg;
  logic       wb_jal;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
    output issue_wr, issue_dst, issue_jal,
    input  issue_ready,
    output wb_valid, wb_reg, wb_jal
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
    input  issue_wr, issue_dst, issue_jal,
    output issue_ready,
    input  wb_valid, wb_reg, wb_jal
  );
endinterface

// File: rtl/gp_reg_scoreboard.sv
// rtl/gp_reg_scoreboard.sv - busy-bit scoreboard gating issue on RAW/WAW hazards and write limit
module gp_reg_scoreboard #(
  parameter int MAX_OUT = 8,
  parameter int OUT_W   = 5,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  gp_reg_scoreboard_if.slave bus,
  output logic [31:0]        busy_vec,
  output logic [OUT_W-1:0]   outstanding,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               err_wb
);

  // Two extra bits so outstanding plus up to two new sets never wraps.
  localparam int SUM_W = OUT_W + 2;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic              wr_nz;
  logic              jal_extra;
  logic              wbr_nz;
  logic [1:0]        n_set;
  logic [1:0]        n_clr;
  logic [31:0]       set_req;
  logic [31:0]       set_vec;
  logic [31:0]       clr_req;
  logic [31:0]       clr_ok;
  logic [31:0]       busy_next;
  logic [SUM_W-1:0]  sum;
  logic              hazard;
  logic              over_limit;
  logic              ready;
  logic              fire;
  logic              spurious;

  assign wr_nz     = bus.issue_wr & (bus.issue_dst != 5'd0);
  // dst=31 together with jal is a single new busy register, not two.
  assign jal_extra = bus.issue_jal & ~(wr_nz & (bus.issue_dst == 5'd31));
  assign n_set     = 2'(wr_nz) + 2'(jal_extra);
  assign wbr_nz    = bus.wb_valid & (bus.wb_reg != 5'd0);

  // Requested set and clear masks; $0 never appears in either.
  always_comb begin
    set_req = '0;
    clr_req = '0;
    if (wr_nz)         set_req[bus.issue_dst] = 1'b1;
    if (bus.issue_jal) set_req[31]            = 1'b1;
    if (wbr_nz)        clr_req[bus.wb_reg]    = 1'b1;
    if (bus.wb_jal)    clr_req[31]            = 1'b1;
  end

  // Issue gating looks only at registered state, so a writeback this cycle does not unblock.
  always_comb begin
    hazard = (bus.issue_use_rs & (bus.issue_rs != 5'd0) & busy_vec[bus.issue_rs])
           | (bus.issue_use_rt & (bus.issue_rt != 5'd0) & busy_vec[bus.issue_rt])
           | (wr_nz & busy_vec[bus.issue_dst])
           | (bus.issue_jal & busy_vec[31]);
    sum        = SUM_W'(outstanding) + SUM_W'(n_set);
    over_limit = sum > SUM_W'(MAX_OUT);
    ready      = ~rst & ~hazard & ~over_limit;
  end

  assign bus.issue_ready = ready;
  assign fire            = bus.issue_valid & ready;
  assign set_vec         = fire ? set_req : 32'd0;

  // A clear only counts against a bit that is busy before the edge; anything else is an error.
  // Sets only land on idle bits, so a same-cycle set and clear always looks spurious here.
  always_comb begin
    clr_ok    = clr_req & busy_vec;
    spurious  = |(clr_req & ~busy_vec);
    busy_next = ((busy_vec & ~clr_ok) | set_vec) & 32'hFFFF_FFFE;
    n_clr     = 2'd0;
    for (int i = 0; i < 32; i++) begin
      n_clr = n_clr + 2'(clr_ok[i]);
    end
  end

  // Scoreboard state, outstanding count, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec    <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
      err_wb      <= 1'b0;
    end else begin
      busy_vec    <= busy_next;
      outstanding <= outstanding + OUT_W'(fire ? n_set : 2'd0) - OUT_W'(n_clr);
      err_wb      <= err_wb | spurious;
      if (bus.issue_valid && !ready && stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
